counter_run_controller: RTL and testbench
=========================================

Name: counter_run_controller

Overview:
- Sequencer for the 4-bit synchronous BCD counter that drives the 7-segment display.
- Derives a slow step tick from the 50 MHz board clock and runs a start/pause/done FSM from a push-button.
- Applies count direction from a switch, and issues single-cycle step/load strobes to the counter.
- Sits between the board pins and the counter; the counter's value is fed back for terminal detection.

Parameters:
- CLK_HZ, 50000000: board clock frequency.
- TICK_HZ, 1: step rate. DIV = CLK_HZ/TICK_HZ; DIV must be ≥ 2.
- DEBOUNCE_CYCLES, 1000000: cycles the button must be stable before it is accepted (20 ms at 50 MHz).
- MAX_VAL, 9: terminal value when counting up; start value when counting down. Range 1..15.

Ports:
- PIN_Y2, input, 1: system clock, rising edge.
- KEY_0, input, 1: reset, asynchronous, active-low.
- KEY_3, input, 1: start/pause button, active-low, asynchronous to PIN_Y2.
- SW17, input, 1: direction; 0 = up, 1 = down; asynchronous.
- count, input, 4: current counter value, bit 3 = MSB (W).
- cnt_en, output, 1: one-cycle step strobe to the counter.
- cnt_up, output, 1: direction level to the counter; 1 = up.
- cnt_load, output, 1: one-cycle load strobe.
- load_val, output, 4: value to load; valid while cnt_load = 1.
- running, output, 1: high in RUN (LED).
- state_o, output, 2: FSM state code.

Behaviour:
- Reset (KEY_0 = 0) is asynchronous, no clock required:
  - state = IDLE, prescaler = 0, debounce counter = 0, debounced button = 1 (released).
  - All outputs = 0, except cnt_up = 1.
- Input conditioning:
  - KEY_3 and SW17 each pass through a 2-FF synchronizer.
  - KEY_3 is then debounced: the debounced value updates only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles. The counter restarts on any bounce.
  - press = debounced 1→0 transition; one-cycle pulse. Releases are ignored.
- Direction and terminal:
  - cnt_up = ~SW17_sync, registered, updated every cycle in every state except reset.
  - start = (cnt_up ? 0 : MAX_VAL).
  - terminal = (cnt_up ? count ≥ MAX_VAL : count == 0).
- Prescaler:
  - Counts 0..DIV-1 only in RUN; tick is the cycle it equals DIV-1, then it wraps to 0.
  - Holds its value in PAUSE.
  - Cleared on any transition into RUN from IDLE or DONE.
- FSM (state_o: IDLE = 00, RUN = 01, PAUSE = 10, DONE = 11):
  - IDLE: press → cnt_load = 1, load_val = start, go to RUN.
  - RUN, press: go to PAUSE. Press has priority over a same-cycle tick: no strobe that cycle.
  - RUN, tick with count > MAX_VAL in down mode (invalid value): cnt_load with load_val = start; stay in RUN.
  - RUN, tick with terminal: go to DONE, no strobe.
  - RUN, any other tick: cnt_en = 1 for one cycle.
  - PAUSE: press → RUN; prescaler resumes from its held value, so phase is preserved.
  - DONE: press → cnt_load = 1, load_val = start, go to RUN.
- Strobe rules:
  - cnt_en and cnt_load are registered, never both high, each at most one cycle per event.
  - Latency: one cycle from the tick or press to the strobe.
- Direction flip mid-RUN: takes effect at the next tick; terminal is re-evaluated with the new direction.
- Reset asserted mid-operation: immediately returns to the reset state; any strobe in progress is dropped.

Optional Feature:
- Macro: COUNTER_AUTO_RESTART_EN.
- Defined: a terminal tick in RUN issues cnt_load = 1 with load_val = start and stays in RUN (continuous wrap 0..MAX_VAL). DONE is unreachable.
- Undefined: a terminal tick enters DONE as specified above.

Test Plan:
Bench parameters: CLK_HZ = 8, TICK_HZ = 1 (DIV = 8), DEBOUNCE_CYCLES = 4, MAX_VAL = 9; a behavioural counter model is fed back on count.
- Reset, then SW17 = 0, then press → exactly one cnt_load with load_val = 0; state_o = 01; thereafter cnt_en every 8 cycles; count steps 0..9; at count = 9 the next tick gives state_o = 11 and no strobe.
- KEY_3 bounce 1-0-1-0 with 2-cycle glitches, then held 0 for 6 cycles → exactly one press; the 2-cycle glitches produce no state change.
- In RUN with the prescaler at 5, press → PAUSE for 20 cycles with no strobes; press again → first cnt_en 2 cycles after re-entering RUN.
- SW17 = 1, start from IDLE → load_val = 9; count steps 9..0; DONE at 0; press in DONE → reload 9 and RUN.
- Force count = 12 with SW17 = 1 in RUN → next tick gives cnt_load with load_val = 9, no cnt_en.
- Assert KEY_0 low mid-RUN during a cnt_en cycle → all outputs 0 (cnt_up = 1) immediately. With COUNTER_AUTO_RESTART_EN defined, count 9 + tick → cnt_load 0 and state stays 01.

Source files
------------

// File: rtl/counter_run_controller.sv
// counter_run_controller
//
// Sequencer for the 4-bit BCD counter that drives the 7-segment display.
// It conditions the board inputs, derives a slow step tick from the board
// clock, and runs an IDLE/RUN/PAUSE/DONE state machine from a push-button.
// It issues single-cycle step/load strobes to the counter and reads the
// counter value back to detect the terminal value.
//
// Optional build macro:
//   COUNTER_AUTO_RESTART_EN - when defined, a terminal tick in RUN reloads
//   the start value and keeps running (continuous wrap); DONE is never
//   entered. When undefined, a terminal tick enters DONE.
//
// Parameters:
//   CLK_HZ          board clock frequency
//   TICK_HZ         step rate; CLK_HZ/TICK_HZ must be >= 2
//   DEBOUNCE_CYCLES cycles the button must differ before it is accepted
//   MAX_VAL         terminal value counting up, start value counting down
//
// Ports:
//   PIN_Y2   in   system clock, rising edge
//   KEY_0    in   asynchronous active-low reset
//   KEY_3    in   start/pause button, active-low, asynchronous
//   SW17     in   direction switch (0 = up, 1 = down), asynchronous
//   count    in   [3:0] current counter value
//   cnt_en   out  one-cycle step strobe
//   cnt_up   out  direction level to the counter (1 = up)
//   cnt_load out  one-cycle load strobe
//   load_val out  [3:0] value to load, valid while cnt_load = 1
//   running  out  high while in RUN
//   state_o  out  [1:0] state code: IDLE 00, RUN 01, PAUSE 10, DONE 11

module counter_run_controller #(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_VAL         = 9
) (
  input  logic       PIN_Y2,
  input  logic       KEY_0,
  input  logic       KEY_3,
  input  logic       SW17,
  input  logic [3:0] count,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic       cnt_load,
  output logic [3:0] load_val,
  output logic       running,
  output logic [1:0] state_o
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       MAX_V    = 4'(MAX_VAL);

  if (DIV < 2) begin : g_bad_div
    $error("counter_run_controller: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (MAX_VAL < 1 || MAX_VAL > 15) begin : g_bad_max
    $error("counter_run_controller: MAX_VAL must be in 1..15");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("counter_run_controller: DEBOUNCE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t state, state_n;

  // ---- Stage p0/p1: two-flop synchronizers for the asynchronous inputs ----
  logic key_meta_p0, key_sync_p1;
  logic sw_meta_p0, sw_sync_p1;

  always_ff @(posedge PIN_Y2 or negedge KEY_0) begin
    if (!KEY_0) begin
      key_meta_p0 <= 1'b1;
      key_sync_p1 <= 1'b1;
      sw_meta_p0  <= 1'b0;
      sw_sync_p1  <= 1'b0;
    end else begin
      key_meta_p0 <= KEY_3;
      key_sync_p1 <= key_meta_p0;
      sw_meta_p0  <= SW17;
      sw_sync_p1  <= sw_meta_p0;
    end
  end

  // ---- Stage p2: debounce and press edge detection ----
  logic [DB_W-1:0] db_cnt_p2;
  logic            key_db_p2;
  logic            key_db_q_p2;
  logic            press;

  always_ff @(posedge PIN_Y2 or negedge KEY_0) begin
    if (!KEY_0) begin
      db_cnt_p2   <= '0;
      key_db_p2   <= 1'b1;
      key_db_q_p2 <= 1'b1;
    end else begin
      key_db_q_p2 <= key_db_p2;
      if (key_sync_p1 == key_db_p2) begin
        // Any return to the accepted level restarts the stability window.
        db_cnt_p2 <= '0;
      end else if (db_cnt_p2 == DB_LAST) begin
        key_db_p2 <= key_sync_p1;
        db_cnt_p2 <= '0;
      end else begin
        db_cnt_p2 <= db_cnt_p2 + DB_W'(1);
      end
    end
  end

  // Only the falling edge (button pushed) matters; releases are ignored.
  assign press = key_db_q_p2 & ~key_db_p2;

  // ---- Stage p2: registered direction level ----
  always_ff @(posedge PIN_Y2 or negedge KEY_0) begin
    if (!KEY_0) begin
      cnt_up <= 1'b1;
    end else begin
      cnt_up <= ~sw_sync_p1;
    end
  end

  // Start value and terminal test follow the current direction, so a flip
  // mid-run is honoured at the next tick.
  logic [3:0] start_val;
  logic       terminal;
  logic       invalid;

  assign start_val = cnt_up ? 4'd0 : MAX_V;
  assign terminal  = cnt_up ? (count >= MAX_V) : (count == 4'd0);
  assign invalid   = ~cnt_up & (count > MAX_V);

  // ---- Prescaler: advances on every RUN cycle, frozen otherwise ----
  logic [PRE_W-1:0] presc;
  logic             presc_clr;
  logic             tick;

  assign tick = (state == S_RUN) && (presc == PRE_LAST);

  always_ff @(posedge PIN_Y2 or negedge KEY_0) begin
    if (!KEY_0) begin
      presc <= '0;
    end else if (presc_clr) begin
      presc <= '0;
    end else if (state == S_RUN) begin
      // The press cycle that leaves RUN still advances the prescaler;
      // PAUSE then holds that value so the phase carries over on resume.
      presc <= tick ? '0 : presc + PRE_W'(1);
    end
  end

  // ---- FSM next-state and strobe decode ----
  logic       cnt_en_n;
  logic       cnt_load_n;
  logic [3:0] load_val_n;

  always_comb begin
    state_n    = state;
    cnt_en_n   = 1'b0;
    cnt_load_n = 1'b0;
    load_val_n = load_val;
    presc_clr  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (press) begin
          state_n    = S_RUN;
          cnt_load_n = 1'b1;
          load_val_n = start_val;
          presc_clr  = 1'b1;
        end
      end
      S_RUN: begin
        // A press wins over a coincident tick; that tick is dropped.
        if (press) begin
          state_n = S_PAUSE;
        end else if (tick) begin
          if (invalid) begin
            cnt_load_n = 1'b1;
            load_val_n = start_val;
          end else if (terminal) begin
`ifdef COUNTER_AUTO_RESTART_EN
            cnt_load_n = 1'b1;
            load_val_n = start_val;
`else
            state_n    = S_DONE;
`endif
          end else begin
            cnt_en_n = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (press) begin
          state_n = S_RUN;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // ---- Stage p3: registered state and strobes ----
  always_ff @(posedge PIN_Y2 or negedge KEY_0) begin
    if (!KEY_0) begin
      state    <= S_IDLE;
      cnt_en   <= 1'b0;
      cnt_load <= 1'b0;
      load_val <= 4'd0;
    end else begin
      state    <= state_n;
      cnt_en   <= cnt_en_n;
      cnt_load <= cnt_load_n;
      load_val <= load_val_n;
    end
  end

  assign running = (state == S_RUN);
  assign state_o = state;

endmodule

// File: tb/tb_counter_run_controller.sv
module tb_counter_run_controller;

  logic       clk = 1'b0;
  logic       KEY_0, KEY_3, SW17;
  logic [3:0] count;
  logic       cnt_en, cnt_up, cnt_load, running;
  logic [3:0] load_val;
  logic [1:0] state_o;

  logic [3:0] model_cnt;
  logic       force_en;
  logic [3:0] force_val;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int both_cnt = 0;

  int         en_q[$];
  int         ld_q[$];
  logic [3:0] ldv_q[$];

  always #5 clk = ~clk;

  assign count = force_en ? force_val : model_cnt;

  counter_run_controller #(
    .CLK_HZ(8), .TICK_HZ(1), .DEBOUNCE_CYCLES(4), .MAX_VAL(9)
  ) dut (
    .PIN_Y2(clk), .KEY_0(KEY_0), .KEY_3(KEY_3), .SW17(SW17),
    .count(count), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_load(cnt_load),
    .load_val(load_val), .running(running), .state_o(state_o)
  );

  // Behavioural BCD counter fed back to the DUT.
  always_ff @(posedge clk or negedge KEY_0) begin
    if (!KEY_0) model_cnt <= 4'd0;
    else if (cnt_load) model_cnt <= load_val;
    else if (cnt_en) begin
      if (cnt_up) model_cnt <= (model_cnt >= 4'd9) ? 4'd0 : model_cnt + 4'd1;
      else        model_cnt <= (model_cnt == 4'd0) ? 4'd9 : model_cnt - 4'd1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cnt_en) en_q.push_back(cyc);
    if (cnt_load) begin
      ld_q.push_back(cyc);
      ldv_q.push_back(load_val);
    end
    if (cnt_en && cnt_load) both_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic clear_q();
    en_q.delete(); ld_q.delete(); ldv_q.delete();
  endtask

  task automatic do_reset(input logic dir);
    KEY_0 = 1'b0; KEY_3 = 1'b1; SW17 = dir; force_en = 1'b0; force_val = 4'd0;
    repeat (3) @(negedge clk);
    KEY_0 = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic press(input int low_cycles);
    KEY_3 = 1'b0;
    repeat (low_cycles) @(negedge clk);
    KEY_3 = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    KEY_0 = 1'b0; KEY_3 = 1'b1; SW17 = 1'b0; force_en = 1'b0; force_val = 4'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cnt_en, cnt_load, load_val, running, state_o, cnt_up} !== 10'b0_0_0000_0_00_1)
      $display("FAIL reset_outputs: got %b expected %b",
               {cnt_en, cnt_load, load_val, running, state_o, cnt_up}, 10'b0_0_0000_0_00_1);
    else n_pass++;
    KEY_0 = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (state_o !== 2'b00) $display("FAIL idle_after_reset: got %b expected 00", state_o);
    else n_pass++;
    n_checks++;
    if (cnt_up !== 1'b1) $display("FAIL cnt_up_after_reset: got %b expected 1", cnt_up);
    else n_pass++;
  endtask

  task automatic test_count_up();
    int w, bad, done_cyc, last_en;
    clear_q();
    press(8);
    n_checks++;
    if (state_o !== 2'b01) $display("FAIL up_run_state: got %b expected 01", state_o);
    else n_pass++;
    w = 0;
    while (state_o != 2'b11 && ld_q.size() < 2 && w < 150) begin
      @(negedge clk); w++;
    end
    done_cyc = cyc;
    n_checks++;
    if (w >= 150) $display("FAIL up_terminal_timeout: waited %0d cycles, limit 150", w);
    else n_pass++;
    n_checks++;
    if (ldv_q.size() < 1 || ldv_q[0] !== 4'd0)
      $display("FAIL up_start_load: got %0d loads first %0d expected load_val 0",
               ldv_q.size(), (ldv_q.size() > 0) ? ldv_q[0] : 4'hf);
    else n_pass++;
    n_checks++;
    if (en_q.size() !== 9) $display("FAIL up_step_count: got %0d expected 9", en_q.size());
    else n_pass++;
    bad = 0;
    for (int i = 0; i < en_q.size(); i++)
      if (ld_q.size() < 1 || en_q[i] - ld_q[0] != 8 * (i + 1)) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL up_step_spacing: got %0d off-grid steps expected 0", bad);
    else n_pass++;
    last_en = (en_q.size() > 0) ? en_q[en_q.size() - 1] : 0;
`ifdef COUNTER_AUTO_RESTART_EN
    n_checks++;
    if (ld_q.size() !== 2 || ldv_q[1] !== 4'd0 || state_o !== 2'b01)
      $display("FAIL auto_restart: got loads %0d state %b expected 2 loads, state 01",
               ld_q.size(), state_o);
    else n_pass++;
    n_checks++;
    if (ld_q.size() < 2 || ld_q[1] - last_en != 8)
      $display("FAIL auto_restart_timing: got %0d expected 8",
               (ld_q.size() > 1) ? ld_q[1] - last_en : -1);
    else n_pass++;
`else
    n_checks++;
    if (ld_q.size() !== 1) $display("FAIL up_load_count: got %0d expected 1", ld_q.size());
    else n_pass++;
    n_checks++;
    if (model_cnt !== 4'd9) $display("FAIL up_final_count: got %0d expected 9", model_cnt);
    else n_pass++;
    n_checks++;
    if (done_cyc - last_en != 8)
      $display("FAIL up_done_timing: got %0d expected 8", done_cyc - last_en);
    else n_pass++;
    repeat (16) @(negedge clk);
    n_checks++;
    if (state_o !== 2'b11 || en_q.size() !== 9 || ld_q.size() !== 1 || running !== 1'b0)
      $display("FAIL done_quiet: got state %b en %0d ld %0d expected 11, 9, 1",
               state_o, en_q.size(), ld_q.size());
    else n_pass++;
`endif
  endtask

  task automatic test_bounce();
    do_reset(1'b0);
    clear_q();
    for (int g = 0; g < 2; g++) begin
      KEY_3 = 1'b0; repeat (2) @(negedge clk);
      KEY_3 = 1'b1; repeat (2) @(negedge clk);
    end
    n_checks++;
    if (state_o !== 2'b00 || ld_q.size() !== 0)
      $display("FAIL glitch_ignored: got state %b loads %0d expected 00, 0", state_o, ld_q.size());
    else n_pass++;
    KEY_3 = 1'b0; repeat (6) @(negedge clk);
    KEY_3 = 1'b1; repeat (10) @(negedge clk);
    n_checks++;
    if (ld_q.size() !== 1 || state_o !== 2'b01)
      $display("FAIL bounce_one_press: got loads %0d state %b expected 1, 01", ld_q.size(), state_o);
    else n_pass++;
    repeat (12) @(negedge clk);
    n_checks++;
    if (ld_q.size() !== 1 || state_o !== 2'b01)
      $display("FAIL release_ignored: got loads %0d state %b expected 1, 01", ld_q.size(), state_o);
    else n_pass++;
  endtask

  task automatic test_pause();
    int w, n_en0, n_ld0;
    logic e0, e1, e2;
    w = 0;
    do begin @(negedge clk); w++; end while (!cnt_en && w < 20);
    n_checks++;
    if (!cnt_en) $display("FAIL pause_sync_step: got no cnt_en in %0d cycles, expected one", w);
    else n_pass++;
    // Prescaler reads 5 when the press reaches the FSM.
    repeat (7) @(negedge clk);
    KEY_3 = 1'b0;
    w = 0;
    while (state_o != 2'b10 && w < 12) begin @(negedge clk); w++; end
    n_checks++;
    if (state_o !== 2'b10 || w !== 7)
      $display("FAIL pause_entry: got state %b after %0d cycles expected 10 after 7", state_o, w);
    else n_pass++;
    KEY_3 = 1'b1;
    n_en0 = en_q.size(); n_ld0 = ld_q.size();
    repeat (20) @(negedge clk);
    n_checks++;
    if (en_q.size() !== n_en0 || ld_q.size() !== n_ld0)
      $display("FAIL pause_no_strobe: got %0d strobes expected 0",
               en_q.size() - n_en0 + ld_q.size() - n_ld0);
    else n_pass++;
    n_checks++;
    if (state_o !== 2'b10 || running !== 1'b0)
      $display("FAIL pause_hold: got state %b running %b expected 10, 0", state_o, running);
    else n_pass++;
    KEY_3 = 1'b0;
    w = 0;
    while (state_o != 2'b01 && w < 12) begin @(negedge clk); w++; end
    e0 = cnt_en;
    @(negedge clk); e1 = cnt_en;
    @(negedge clk); e2 = cnt_en;
    KEY_3 = 1'b1;
    n_checks++;
    if (w >= 12) $display("FAIL resume_timeout: waited %0d cycles, limit 12", w);
    else n_pass++;
    n_checks++;
    if ({e0, e1, e2} !== 3'b001)
      $display("FAIL resume_phase: got cnt_en pattern %b expected 001", {e0, e1, e2});
    else n_pass++;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_count_down();
    int w;
    do_reset(1'b1);
    n_checks++;
    if (cnt_up !== 1'b0) $display("FAIL down_dir: got %b expected 0", cnt_up);
    else n_pass++;
    clear_q();
    press(8);
    n_checks++;
    if (ld_q.size() !== 1 || ldv_q[0] !== 4'd9 || state_o !== 2'b01)
      $display("FAIL down_start_load: got loads %0d state %b expected 1 load of 9, state 01",
               ld_q.size(), state_o);
    else n_pass++;
    w = 0;
    while (state_o != 2'b11 && ld_q.size() < 2 && w < 150) begin @(negedge clk); w++; end
    n_checks++;
    if (en_q.size() !== 9) $display("FAIL down_step_count: got %0d expected 9", en_q.size());
    else n_pass++;
`ifdef COUNTER_AUTO_RESTART_EN
    n_checks++;
    if (ld_q.size() !== 2 || ldv_q[1] !== 4'd9 || state_o !== 2'b01)
      $display("FAIL down_auto_restart: got loads %0d state %b expected 2, 01", ld_q.size(), state_o);
    else n_pass++;
`else
    n_checks++;
    if (state_o !== 2'b11 || model_cnt !== 4'd0)
      $display("FAIL down_done: got state %b count %0d expected 11, 0", state_o, model_cnt);
    else n_pass++;
    clear_q();
    press(8);
    n_checks++;
    if (ld_q.size() !== 1 || ldv_q[0] !== 4'd9 || state_o !== 2'b01)
      $display("FAIL done_reload: got loads %0d state %b expected 1 load of 9, state 01",
               ld_q.size(), state_o);
    else n_pass++;
`endif
  endtask

  task automatic test_invalid();
    int w;
    force_val = 4'd12; force_en = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!cnt_en && !cnt_load && w < 20);
    n_checks++;
    if (cnt_load !== 1'b1 || cnt_en !== 1'b0 || load_val !== 4'd9)
      $display("FAIL invalid_reload: got load %b en %b val %0d expected 1, 0, 9",
               cnt_load, cnt_en, load_val);
    else n_pass++;
    n_checks++;
    if (state_o !== 2'b01) $display("FAIL invalid_stay_run: got %b expected 01", state_o);
    else n_pass++;
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    w = 0;
    do begin @(negedge clk); w++; end while (!cnt_en && w < 20);
    n_checks++;
    if (!cnt_en) $display("FAIL midreset_step: got no cnt_en in %0d cycles, expected one", w);
    else n_pass++;
    #1 KEY_0 = 1'b0;
    #1;
    n_checks++;
    if ({cnt_en, cnt_load, load_val, running, state_o, cnt_up} !== 10'b0_0_0000_0_00_1)
      $display("FAIL midreset_outputs: got %b expected %b",
               {cnt_en, cnt_load, load_val, running, state_o, cnt_up}, 10'b0_0_0000_0_00_1);
    else n_pass++;
    @(negedge clk);
    KEY_0 = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (both_cnt !== 0) $display("FAIL strobe_exclusive: got %0d overlaps expected 0", both_cnt);
    else n_pass++;
  endtask

  initial begin
    KEY_0 = 1'b0; KEY_3 = 1'b1; SW17 = 1'b0; force_en = 1'b0; force_val = 4'd0;
    test_reset();
    test_count_up();
    test_bounce();
    test_pause();
    test_count_down();
    test_invalid();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
